// File: rtl/muldiv_ctrl_pkg.sv
// Shared ALU control codes for the HI/LO unit and divider constants.
// Also holds the magnitude helper used by the divider datapath.
package muldiv_ctrl_pkg;

    localparam logic [4:0] ADD_CONTROL   = 5'b00010;
    localparam logic [4:0] MULT_CONTROL  = 5'b10000;
    localparam logic [4:0] MULTU_CONTROL = 5'b10001;
    localparam logic [4:0] DIV_CONTROL   = 5'b10010;
    localparam logic [4:0] DIVU_CONTROL  = 5'b10011;
    localparam logic [4:0] MTHI_CONTROL  = 5'b10100;
    localparam logic [4:0] MTLO_CONTROL  = 5'b10101;

    localparam int unsigned DIV_ITERS = 32;

    function automatic logic [31:0] abs32(input logic [31:0] v, input logic is_signed);
        return (is_signed && v[31]) ? (~v + 32'd1) : v;
    endfunction

endpackage

// File: rtl/div_iter.sv
// Combinational restoring-division step plus magnitude conversion and sign fix-up.
// Divide-by-zero bypasses the fix-up: quotient all ones, remainder is the raw dividend.
module div_iter
    import muldiv_ctrl_pkg::*;
(
    input  logic        is_signed,
    input  logic [31:0] dividend,
    input  logic [31:0] divisor,
    input  logic [31:0] rem_in,
    input  logic [31:0] quo_in,
    output logic [31:0] dividend_mag,
    output logic [31:0] rem_out,
    output logic [31:0] quo_out,
    output logic [31:0] lo_res,
    output logic [31:0] hi_res
);

    logic [31:0] divisor_mag;
    logic [32:0] shifted;
    logic [32:0] diff;
    logic        neg_q;
    logic        neg_r;

    always_comb begin
        dividend_mag = abs32(dividend, is_signed);
        divisor_mag  = abs32(divisor, is_signed);

        // The quotient register doubles as the dividend shift source.
        shifted = {rem_in, quo_in[31]};
        diff    = shifted - {1'b0, divisor_mag};
        if (diff[32]) begin
            rem_out = shifted[31:0];
            quo_out = {quo_in[30:0], 1'b0};
        end else begin
            rem_out = diff[31:0];
            quo_out = {quo_in[30:0], 1'b1};
        end

        neg_q = is_signed & (dividend[31] ^ divisor[31]);
        neg_r = is_signed & dividend[31];
        if (divisor == '0) begin
            lo_res = '1;
            hi_res = dividend;
        end else begin
            lo_res = neg_q ? (~quo_in + 32'd1) : quo_in;
            hi_res = neg_r ? (~rem_in + 32'd1) : rem_in;
        end
    end

endmodule

// File: rtl/muldiv_ctrl.sv
// HI/LO owner: single-cycle MULT/MULTU/MTHI/MTLO and a 32-iteration stalling divider.
// Define MULDIV_DIV0_EARLY_EN to finish divide-by-zero without iterating.
module muldiv_ctrl
    import muldiv_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  alucontrolE,
    input  logic        validE,
    input  logic        flushE,
    input  logic [31:0] srcaE,
    input  logic [31:0] srcbE,
    output logic        stallE,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o,
    output logic        busy
);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e      state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [31:0] hi_q, hi_d, lo_q, lo_d;
    logic [31:0] opa_q, opa_d, opb_q, opb_d;
    logic [31:0] rem_q, rem_d, quo_q, quo_d;
    logic        sgn_q, sgn_d;

    logic        accept;
    logic        idle;
    logic        iter_signed;
    logic [31:0] iter_a, iter_b;
    logic [31:0] dividend_mag, rem_next, quo_next, lo_res, hi_res;
    logic [63:0] prod_s, prod_u;

    assign accept = validE & ~flushE;
    assign idle   = (state_q == StIdle);

    // On the accept cycle the datapath sees the live E-stage operands, afterwards the latches.
    assign iter_signed = idle ? (alucontrolE == DIV_CONTROL) : sgn_q;
    assign iter_a      = idle ? srcaE : opa_q;
    assign iter_b      = idle ? srcbE : opb_q;

    div_iter u_div_iter (
        .is_signed    (iter_signed),
        .dividend     (iter_a),
        .divisor      (iter_b),
        .rem_in       (rem_q),
        .quo_in       (quo_q),
        .dividend_mag (dividend_mag),
        .rem_out      (rem_next),
        .quo_out      (quo_next),
        .lo_res       (lo_res),
        .hi_res       (hi_res)
    );

    assign prod_s = $unsigned($signed({{32{srcaE[31]}}, srcaE}) *
                              $signed({{32{srcbE[31]}}, srcbE}));
    assign prod_u = {32'b0, srcaE} * {32'b0, srcbE};

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        opa_d   = opa_q;
        opb_d   = opb_q;
        sgn_d   = sgn_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        stallE  = 1'b0;
        busy    = 1'b0;

        unique case (state_q)
            StIdle: begin
                cnt_d = '0;
                if (accept) begin
                    case (alucontrolE)
                        MTHI_CONTROL:  hi_d = srcaE;
                        MTLO_CONTROL:  lo_d = srcaE;
                        MULT_CONTROL:  {hi_d, lo_d} = prod_s;
                        MULTU_CONTROL: {hi_d, lo_d} = prod_u;
                        DIV_CONTROL, DIVU_CONTROL: begin
                            stallE = 1'b1;
                            opa_d  = srcaE;
                            opb_d  = srcbE;
                            sgn_d  = iter_signed;
                            rem_d  = '0;
                            quo_d  = dividend_mag;
`ifdef MULDIV_DIV0_EARLY_EN
                            state_d = (srcbE == '0) ? StDone : StRun;
`else
                            state_d = StRun;
`endif
                        end
                        default: ;
                    endcase
                end
            end
            StRun: begin
                busy   = 1'b1;
                stallE = 1'b1;
                rem_d  = rem_next;
                quo_d  = quo_next;
                cnt_d  = cnt_q + 5'd1;
                if (flushE) begin
                    state_d = StIdle;
                end else if (cnt_q == 5'(DIV_ITERS - 1)) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                // E stage is released here; a flush of the divide drops the result.
                if (!flushE) begin
                    lo_d = lo_res;
                    hi_d = hi_res;
                end
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            opa_q   <= '0;
            opb_q   <= '0;
            sgn_q   <= 1'b0;
            rem_q   <= '0;
            quo_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            opa_q   <= opa_d;
            opb_q   <= opb_d;
            sgn_q   <= sgn_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
        end
    end

    assign hi_o = hi_q;
    assign lo_o = lo_q;

endmodule
